// File: rtl/sram_ctrl_pkg.sv
// sram_ctrl_pkg -- shared types and helpers for the external SRAM initiator.
//   state_t      : controller FSM states
//   SIZE_BYTE/HALF: encodings of req_size
//   lane_decode  : (addr0, size) -> {ubn, lbn} active-low byte-lane strobes
package sram_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE,
    READ,
    WSETUP,
    WRITE,
    WHOLD
  } state_t;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_HALF = 1'b1;

  // Even byte addresses live on the low lane, odd ones on the high lane.
  function automatic logic [1:0] lane_decode(input logic addr0, input logic size);
    if (size == SIZE_HALF) return 2'b00;
    return {~addr0, addr0};
  endfunction

endpackage

// File: rtl/sram_ctrl.sv
// sram_ctrl -- initiator for an external asynchronous 16-bit SRAM.
// Turns single byte/halfword requests into registered, glitch-free SRAM
// read and write cycles. Writes have one setup and one hold cycle around
// the WEn pulse.
//
// Ports:
//   clk, rst_n                 clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake
//   req_write, req_size        1 = write / 1 = halfword
//   req_addr [W_ADDR:0]        byte address
//   req_wdata[15:0]            write data (byte writes use [7:0])
//   resp_valid, resp_err       one-cycle completion pulse, misaligned flag
//   resp_rdata[15:0]           read data, held until the next read completes
//   sram_a, sram_dq_o, sram_dq_oe, sram_dq_i   address / data pads
//   sram_csn, sram_oen, sram_wen, sram_ubn, sram_lbn  active-low strobes
//
// Build option: define SRAM_CTRL_PIPELINED_READ_EN to accept a following
// aligned read in the last READ cycle so back-to-back reads keep CSn low.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int W_ADDR    = 18,
  parameter int W_DATA    = 16,
  parameter int RD_CYCLES = 2,
  parameter int WR_CYCLES = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic              req_size,
  input  logic [W_ADDR:0]   req_addr,
  input  logic [W_DATA-1:0] req_wdata,
  output logic              resp_valid,
  output logic              resp_err,
  output logic [W_DATA-1:0] resp_rdata,
  output logic [W_ADDR-1:0] sram_a,
  output logic [W_DATA-1:0] sram_dq_o,
  output logic              sram_dq_oe,
  input  logic [W_DATA-1:0] sram_dq_i,
  output logic              sram_csn,
  output logic              sram_oen,
  output logic              sram_wen,
  output logic              sram_ubn,
  output logic              sram_lbn
);

  localparam int MAX_CYC = (RD_CYCLES > WR_CYCLES) ? RD_CYCLES : WR_CYCLES;
  localparam int CNT_W   = $clog2(MAX_CYC + 1);
  localparam logic [CNT_W-1:0] RD_LOAD = CNT_W'(RD_CYCLES - 1);
  localparam logic [CNT_W-1:0] WR_LOAD = CNT_W'(WR_CYCLES - 1);

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic              size_q;
  logic              addr0_q;
  logic              misaligned;
  logic              last_rd;
  logic              rd_pipe_ok;
  logic [1:0]        lanes;
  logic [W_DATA-1:0] rd_word;

  assign misaligned = (req_size == SIZE_HALF) && req_addr[0];
  assign last_rd    = (state == READ) && (cnt == '0);
  assign lanes      = lane_decode(req_addr[0], req_size);

`ifdef SRAM_CTRL_PIPELINED_READ_EN
  // Only an aligned read may chain onto the strobes already held low.
  assign rd_pipe_ok = last_rd && !req_write && !misaligned;
`else
  assign rd_pipe_ok = 1'b0;
`endif

  assign req_ready = (state == IDLE) || rd_pipe_ok;

  // Byte reads replicate the selected lane into both halves.
  always_comb begin
    rd_word = sram_dq_i;
    if (size_q == SIZE_BYTE)
      rd_word = addr0_q ? {sram_dq_i[15:8], sram_dq_i[15:8]}
                        : {sram_dq_i[7:0],  sram_dq_i[7:0]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= IDLE;
      cnt        <= '0;
      size_q     <= SIZE_BYTE;
      addr0_q    <= 1'b0;
      sram_a     <= '0;
      sram_dq_o  <= '0;
      sram_dq_oe <= 1'b0;
      sram_csn   <= 1'b1;
      sram_oen   <= 1'b1;
      sram_wen   <= 1'b1;
      sram_ubn   <= 1'b1;
      sram_lbn   <= 1'b1;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
    end else begin
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      case (state)
        IDLE: begin
          if (req_valid) begin
            if (misaligned) begin
              resp_valid <= 1'b1;
              resp_err   <= 1'b1;
            end else begin
              size_q               <= req_size;
              addr0_q              <= req_addr[0];
              sram_a               <= req_addr[W_ADDR:1];
              {sram_ubn, sram_lbn} <= lanes;
              sram_csn             <= 1'b0;
              if (req_write) begin
                sram_dq_o  <= (req_size == SIZE_HALF) ? req_wdata
                                                      : {req_wdata[7:0], req_wdata[7:0]};
                sram_dq_oe <= 1'b1;
                state      <= WSETUP;
              end else begin
                sram_oen <= 1'b0;
                cnt      <= RD_LOAD;
                state    <= READ;
              end
            end
          end
        end

        READ: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            resp_rdata <= rd_word;
            resp_valid <= 1'b1;
            if (req_valid && rd_pipe_ok) begin
              // Chained read: strobes stay low, address moves with the capture.
              size_q               <= req_size;
              addr0_q              <= req_addr[0];
              sram_a               <= req_addr[W_ADDR:1];
              {sram_ubn, sram_lbn} <= lanes;
              cnt                  <= RD_LOAD;
            end else begin
              sram_csn <= 1'b1;
              sram_oen <= 1'b1;
              sram_ubn <= 1'b1;
              sram_lbn <= 1'b1;
              state    <= IDLE;
            end
          end
        end

        WSETUP: begin
          sram_wen <= 1'b0;
          cnt      <= WR_LOAD;
          state    <= WRITE;
        end

        WRITE: begin
          if (cnt != '0) begin
            cnt <= cnt - 1'b1;
          end else begin
            sram_wen <= 1'b1;
            state    <= WHOLD;
          end
        end

        WHOLD: begin
          sram_csn   <= 1'b1;
          sram_dq_oe <= 1'b0;
          sram_ubn   <= 1'b1;
          sram_lbn   <= 1'b1;
          resp_valid <= 1'b1;
          state      <= IDLE;
        end

        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_sram_ctrl.sv
// tb_sram_ctrl -- self-checking bench for sram_ctrl with a behavioural
// SRAM on the pads and a byte-array reference memory.
module tb_sram_ctrl;
  import sram_ctrl_pkg::*;

  localparam int W_ADDR = 18;
  localparam int RD     = 2;
  localparam int WR     = 2;
`ifdef SRAM_CTRL_PIPELINED_READ_EN
  localparam bit PIPE = 1'b1;
`else
  localparam bit PIPE = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic              req_valid = 1'b0;
  logic              req_ready;
  logic              req_write = 1'b0;
  logic              req_size = 1'b0;
  logic [W_ADDR:0]   req_addr = '0;
  logic [15:0]       req_wdata = '0;
  logic              resp_valid, resp_err;
  logic [15:0]       resp_rdata;
  logic [W_ADDR-1:0] sram_a;
  logic [15:0]       sram_dq_o, sram_dq_i;
  logic              sram_dq_oe, sram_csn, sram_oen, sram_wen, sram_ubn, sram_lbn;

  int checks = 0;
  int errors = 0;

  logic [15:0] mem   [0:63];
  logic [7:0]  ref_b [0:127];

  always #5 clk = ~clk;

  sram_ctrl #(.W_ADDR(W_ADDR), .W_DATA(16), .RD_CYCLES(RD), .WR_CYCLES(WR)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_size(req_size), .req_addr(req_addr), .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_err(resp_err), .resp_rdata(resp_rdata),
    .sram_a(sram_a), .sram_dq_o(sram_dq_o), .sram_dq_oe(sram_dq_oe), .sram_dq_i(sram_dq_i),
    .sram_csn(sram_csn), .sram_oen(sram_oen), .sram_wen(sram_wen),
    .sram_ubn(sram_ubn), .sram_lbn(sram_lbn)
  );

  // Asynchronous SRAM: reads drive data while CSn/OEn low, writes land while CSn/WEn low.
  assign sram_dq_i = (!sram_csn && !sram_oen) ? mem[sram_a[5:0]] : 16'hDEAD;

  always @(negedge clk) begin
    if (!sram_csn && !sram_wen) begin
      if (!sram_lbn) mem[sram_a[5:0]][7:0]  = sram_dq_o[7:0];
      if (!sram_ubn) mem[sram_a[5:0]][15:8] = sram_dq_o[15:8];
    end
  end

  // Pin-level invariants observed on every cycle.
  int   oen_hi = 100;
  logic dq_oe_prev = 1'b0;
  always @(negedge clk) begin
    if (rst_n) begin
      if (!sram_csn) begin
        checks++;
        if (!sram_wen && !sram_oen) begin
          errors++;
          $display("FAIL wen_oen_overlap wen=%b oen=%b required not both low", sram_wen, sram_oen);
        end
      end
      if (sram_dq_oe && !dq_oe_prev) begin
        checks++;
        if (oen_hi < 1) begin
          errors++;
          $display("FAIL turnaround oen_high_cycles=%0d required >=1", oen_hi);
        end
      end
    end
    oen_hi     = sram_oen ? ((oen_hi < 100) ? oen_hi + 1 : 100) : 0;
    dq_oe_prev = sram_dq_oe;
  end

  function automatic logic [15:0] ref_read(input logic [18:0] ad, input logic sz);
    int i;
    i = int'(ad[6:0]);
    if (sz == SIZE_HALF) return {ref_b[i+1], ref_b[i]};
    return {ref_b[i], ref_b[i]};
  endfunction

  task automatic ref_write(input logic [18:0] ad, input logic sz, input logic [15:0] wd);
    int i;
    i = int'(ad[6:0]);
    ref_b[i] = wd[7:0];
    if (sz == SIZE_HALF) ref_b[i+1] = wd[15:8];
  endtask

  // Issues one request and observes the pins until its response.
  task automatic transact(input logic wr, input logic sz, input logic [18:0] ad,
                          input logic [15:0] wd, output logic [15:0] rd, output logic er,
                          output int lat, output int wen_low, output int csn_low,
                          output logic [1:0] lanes_seen, output int pin_bad);
    int n;
    rd = '0; er = 1'b0; lat = -1; wen_low = 0; csn_low = 0; lanes_seen = 2'b11; pin_bad = 0;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_size = sz; req_addr = ad; req_wdata = wd;
    n = 0;
    while (!req_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!req_ready) begin
      checks++; errors++;
      $display("FAIL accept_timeout ready=%b required 1", req_ready);
      req_valid = 1'b0;
      return;
    end
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!sram_csn) begin
        csn_low++;
        lanes_seen = {sram_ubn, sram_lbn};
        if (sram_a != ad[18:1] || {sram_ubn, sram_lbn} != lane_decode(ad[0], sz)) pin_bad++;
      end
      if (!sram_wen) begin
        wen_low++;
        if (sram_csn || !sram_dq_oe) pin_bad++;
      end
      if (sram_dq_oe && sram_dq_o != ((sz == SIZE_HALF) ? wd : {wd[7:0], wd[7:0]})) pin_bad++;
      if (resp_valid) begin
        lat = k; rd = resp_rdata; er = resp_err;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      errors++;
      $display("FAIL resp_timeout latency=none required response");
    end
    if (wr && !(sz == SIZE_HALF && ad[0])) ref_write(ad, sz, wd);
  endtask

  task automatic test_reset();
    #1 rst_n = 1'b0;
    #20;
    checks++;
    if ({sram_csn, sram_oen, sram_wen, sram_ubn, sram_lbn, sram_dq_oe} !== 6'b111110) begin
      errors++;
      $display("FAIL reset_strobes got=%b required=111110",
               {sram_csn, sram_oen, sram_wen, sram_ubn, sram_lbn, sram_dq_oe});
    end
    checks++;
    if ({sram_a, sram_dq_o, resp_rdata} !== '0) begin
      errors++;
      $display("FAIL reset_data a=%h dq_o=%h rdata=%h required 0", sram_a, sram_dq_o, resp_rdata);
    end
    checks++;
    if ({resp_valid, resp_err, req_ready} !== 3'b001) begin
      errors++;
      $display("FAIL reset_ctrl got=%b required=001", {resp_valid, resp_err, req_ready});
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_plan_rw();
    logic [15:0] rd; logic er; int lat, wl, cl, pb; logic [1:0] ln;
    transact(1'b1, SIZE_HALF, 19'h10, 16'hBEEF, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (lat != WR + 2 || er !== 1'b0) begin
      errors++; $display("FAIL write_latency lat=%0d err=%b required %0d/0", lat, er, WR + 2);
    end
    checks++;
    if (wl != WR || cl != WR + 2 || pb != 0) begin
      errors++;
      $display("FAIL write_pins wen_low=%0d csn_low=%0d bad=%0d required %0d/%0d/0", wl, cl, pb, WR, WR + 2);
    end
    transact(1'b0, SIZE_HALF, 19'h10, 16'h0, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (lat != RD || rd !== 16'hBEEF || pb != 0) begin
      errors++;
      $display("FAIL read_beef lat=%0d rdata=%h bad=%0d required %0d/beef/0", lat, rd, pb, RD);
    end
  endtask

  task automatic test_byte_lane();
    logic [15:0] rd; logic er; int lat, wl, cl, pb; logic [1:0] ln;
    transact(1'b1, SIZE_BYTE, 19'h11, 16'h005A, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (ln !== 2'b01 || pb != 0) begin
      errors++; $display("FAIL byte_lanes ubn_lbn=%b bad=%0d required 01/0", ln, pb);
    end
    transact(1'b0, SIZE_HALF, 19'h10, 16'h0, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (rd !== 16'h5AEF) begin
      errors++; $display("FAIL byte_merge rdata=%h required 5aef", rd);
    end
    transact(1'b0, SIZE_BYTE, 19'h10, 16'h0, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (rd !== 16'hEFEF || ln !== 2'b10) begin
      errors++; $display("FAIL byte_read_lo rdata=%h lanes=%b required efef/10", rd, ln);
    end
  endtask

  task automatic test_misaligned();
    logic [15:0] rd; logic er; int lat, wl, cl, pb; logic [1:0] ln;
    transact(1'b0, SIZE_HALF, 19'h03, 16'h0, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (lat != 0 || er !== 1'b1 || cl != 0) begin
      errors++; $display("FAIL misaligned_rd lat=%0d err=%b csn_low=%0d required 0/1/0", lat, er, cl);
    end
    transact(1'b1, SIZE_HALF, 19'h21, 16'h1234, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (er !== 1'b1 || wl != 0 || cl != 0) begin
      errors++; $display("FAIL misaligned_wr err=%b wen_low=%0d csn_low=%0d required 1/0/0", er, wl, cl);
    end
  endtask

  task automatic test_turnaround();
    logic [15:0] rd; logic er; int lat, wl, cl, pb; logic [1:0] ln;
    transact(1'b0, SIZE_HALF, 19'h10, 16'h0, rd, er, lat, wl, cl, ln, pb);
    transact(1'b1, SIZE_HALF, 19'h30, 16'hC0DE, rd, er, lat, wl, cl, ln, pb);
    checks++;
    if (lat != WR + 2 || pb != 0) begin
      errors++; $display("FAIL rd_wr_turn lat=%0d bad=%0d required %0d/0", lat, pb, WR + 2);
    end
  endtask

  task automatic test_reset_mid_write();
    int seen;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_size = SIZE_HALF; req_addr = 19'h20; req_wdata = 16'hA55A;
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      if (!sram_wen) break;
    end
    ref_write(19'h20, SIZE_HALF, 16'hA55A);
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if ({sram_csn, sram_wen, sram_oen, sram_dq_oe} !== 4'b1110) begin
      errors++;
      $display("FAIL async_abort csn_wen_oen_oe=%b required 1110", {sram_csn, sram_wen, sram_oen, sram_dq_oe});
    end
    @(negedge clk);
    rst_n = 1'b1;
    seen = 0;
    for (int k = 0; k < 8; k++) begin
      @(negedge clk);
      if (resp_valid) seen++;
    end
    checks++;
    if (seen != 0 || req_ready !== 1'b1) begin
      errors++; $display("FAIL abort_no_resp resp_count=%0d ready=%b required 0/1", seen, req_ready);
    end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int lat, wl, cl, pb; logic [1:0] ln;
    logic [18:0] ads [4];
    logic        szs [4];
    logic [15:0] exp [4];
    int  idx, got, last_t;
    bit  csn_hi_mid, acc;
    int  spacing;
    spacing = PIPE ? RD : RD + 1;
    for (int i = 0; i < 4; i++)
      transact(1'b1, SIZE_HALF, 19'(64 + 2 * i), 16'($urandom), rd, er, lat, wl, cl, ln, pb);
    ads[0] = 19'h40; szs[0] = SIZE_HALF;
    ads[1] = 19'h43; szs[1] = SIZE_BYTE;
    ads[2] = 19'h44; szs[2] = SIZE_HALF;
    ads[3] = 19'h46; szs[3] = SIZE_BYTE;
    for (int i = 0; i < 4; i++) exp[i] = ref_read(ads[i], szs[i]);
    idx = 0; got = 0; last_t = -1; csn_hi_mid = 1'b0;
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b0; req_size = szs[0]; req_addr = ads[0];
    for (int cyc = 0; cyc < 60 && got < 4; cyc++) begin
      acc = req_valid && req_ready;
      if (idx > 0 && !(resp_valid && got == 3) && sram_csn) csn_hi_mid = 1'b1;
      if (resp_valid) begin
        checks++;
        if (resp_rdata !== exp[got]) begin
          errors++; $display("FAIL b2b_rdata idx=%0d rdata=%h required %h", got, resp_rdata, exp[got]);
        end
        if (got > 0) begin
          checks++;
          if (cyc - last_t != spacing) begin
            errors++; $display("FAIL b2b_spacing gap=%0d required %0d", cyc - last_t, spacing);
          end
        end
        last_t = cyc;
        got++;
      end
      @(posedge clk);
      #1;
      if (acc) begin
        idx++;
        if (idx < 4) begin
          req_size = szs[idx]; req_addr = ads[idx];
        end else begin
          req_valid = 1'b0;
        end
      end
      @(negedge clk);
    end
    req_valid = 1'b0;
    checks++;
    if (got != 4 || csn_hi_mid != !PIPE) begin
      errors++; $display("FAIL b2b_csn responses=%0d csn_rose=%b required 4/%b", got, csn_hi_mid, !PIPE);
    end
  endtask

  task automatic test_random();
    logic [15:0] rd, wd; logic er; int lat, wl, cl, pb; logic [1:0] ln;
    logic wr, sz, mis; logic [18:0] ad; logic [15:0] exp;
    for (int t = 0; t < 30; t++) begin
      wr = 1'($urandom_range(0, 1));
      sz = 1'($urandom_range(0, 1));
      ad = 19'($urandom_range(0, 127));
      wd = 16'($urandom);
      mis = (sz == SIZE_HALF) && ad[0];
      exp = ref_read(ad, sz);
      transact(wr, sz, ad, wd, rd, er, lat, wl, cl, ln, pb);
      checks++;
      if (er !== mis || lat != (mis ? 0 : (wr ? WR + 2 : RD)) || pb != 0) begin
        errors++;
        $display("FAIL rand_resp t=%0d err=%b lat=%0d bad=%0d required err=%b", t, er, lat, pb, mis);
      end
      if (!wr && !mis) begin
        checks++;
        if (rd !== exp) begin
          errors++; $display("FAIL rand_rdata t=%0d addr=%h rdata=%h required %h", t, ad, rd, exp);
        end
      end
      if (wr && !mis) begin
        checks++;
        if (wl != WR) begin
          errors++; $display("FAIL rand_wen t=%0d wen_low=%0d required %0d", t, wl, WR);
        end
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 64; i++) mem[i] = '0;
    for (int i = 0; i < 128; i++) ref_b[i] = '0;
    test_reset();
    test_plan_rw();
    test_byte_lane();
    test_misaligned();
    test_turnaround();
    test_reset_mid_write();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #400000;
    $display("FAIL watchdog simulation did not complete");
    $fatal(1);
  end

endmodule

// File: doc/sram_ctrl.md
Name: sram_ctrl

Overview:
- On-chip initiator for the external asynchronous 16-bit SRAM (SRAM_A/DQ/CSn/OEn/WEn/UBn/LBn pads).
- Sits between the system bus adapter and the pad ring.
- Converts single byte/halfword requests into fully registered, glitch-free SRAM read and write cycles with parameterised wait states.
- The write cycle has explicit data setup and hold.

Parameters:
W_ADDR, 18, SRAM halfword address width; request byte address is W_ADDR+1 bits.
W_DATA, 16, SRAM data width; fixed at 16, byte lanes are hardwired.
RD_CYCLES, 2, cycles CSn/OEn are held low per read, must be >= 1.
WR_CYCLES, 2, cycles WEn is held low per write, must be >= 1.

Ports:
clk  input  1  system clock.
rst_n  input  1  reset; asynchronous assert, active-low.
req_valid  input  1  request present.
req_ready  output  1  request accepted when valid && ready at rising edge.
req_write  input  1  1 = write, 0 = read.
req_size  input  1  0 = byte, 1 = halfword.
req_addr  input  W_ADDR+1  byte address.
req_wdata  input  16  write data; byte writes use [7:0].
resp_valid  output  1  one-cycle completion pulse.
resp_err  output  1  valid with resp_valid; misaligned request.
resp_rdata  output  16  read data, valid with resp_valid on reads.
sram_a  output  W_ADDR  halfword address pins.
sram_dq_o  output  16  data out to pads.
sram_dq_oe  output  1  pad output enable.
sram_dq_i  input  16  data in from pads.
sram_csn, sram_oen, sram_wen, sram_ubn, sram_lbn  output  1 each  active-low strobes.

Behaviour:
- Reset values:
  - csn, oen, wen, ubn, lbn = 1.
  - dq_oe = 0; a, dq_o, resp_rdata = 0.
  - resp_valid = 0, resp_err = 0, req_ready = 1.
  - State = IDLE.
- All pin outputs are registered flops. No pin is combinationally derived.
- States: IDLE, READ, WSETUP, WRITE, WHOLD.
- IDLE:
  - req_ready = 1.
  - On accept, latch addr, size, wdata, write.
  - Halfword with addr[0] = 1: no pin activity; resp_valid = resp_err = 1 in the cycle after accept; stay in IDLE.
- Lanes:
  - Halfword: ubn = lbn = 0.
  - Byte: lbn = addr[0], ubn = ~addr[0].
  - sram_a = addr[W_ADDR:1].
  - Byte write drives {wdata[7:0], wdata[7:0]}.
  - Byte read returns the selected byte replicated in both halves of resp_rdata.
- READ (accepted at edge E):
  - csn = oen = 0 from E to E+RD_CYCLES.
  - sram_dq_i is captured into resp_rdata at edge E+RD_CYCLES.
  - csn/oen return to 1 at the same edge. resp_valid is high for the cycle starting E+RD_CYCLES.
  - Next state is IDLE.
  - Latency = RD_CYCLES.
- Write (accepted at edge E):
  - WSETUP, 1 cycle: csn = 0, wen = 1, dq_oe = 1, a/dq/lanes valid.
  - WRITE, WR_CYCLES cycles: wen = 0.
  - WHOLD, 1 cycle: wen = 1, csn = 0, dq_oe = 1, data unchanged.
  - Then IDLE with csn = 1, dq_oe = 0, resp_valid = 1.
  - Latency = WR_CYCLES + 2.
- req_ready = 0 in every state other than IDLE, except as in Optional Feature.
- A new request can be accepted in the same cycle resp_valid is high (IDLE).
- Read→write turnaround: dq_oe rises at least one full cycle after oen rises. This follows from acceptance only in IDLE and must be preserved.
- Invariant: wen and oen are never both 0.
- Reset mid-cycle: all strobes return high and dq_oe drops asynchronously. No response is issued for the aborted access.
- resp_rdata holds its last value until the next read completes.

Optional Feature:
- Macro: SRAM_CTRL_PIPELINED_READ_EN.
- Defined:
  - In the final READ cycle, req_ready = !req_write (combinational on the request) and the request must be aligned.
  - An accepted read keeps csn/oen low; a, ubn, lbn update at the same edge the previous data is captured.
  - Back-to-back reads therefore issue every RD_CYCLES cycles.
  - Writes and misaligned requests still wait for IDLE.
- Undefined: reads are separated by one IDLE cycle with csn high.

Decomposition:
- Package sram_ctrl_pkg holds:
  - the state enum;
  - SIZE_BYTE/SIZE_HALF constants;
  - a lane-decode function (addr0, size → {ubn, lbn}) shared with the testbench SRAM checker.
- No sub-module; one FSM plus a wait counter of width $clog2(max(RD_CYCLES, WR_CYCLES) + 1).

Test Plan:
- Halfword write 0xBEEF to byte addr 0x00010, then read (RD_CYCLES = 2, WR_CYCLES = 2):
  - sram_a = 0x00008, wen low exactly 2 cycles inside csn low;
  - write resp after 4 cycles; read resp after 2 cycles with rdata 0xBEEF.
- Byte write 0x5A to addr 0x00011, then halfword read of 0x00010:
  - ubn = 0, lbn = 1 during the write;
  - rdata = 0x5AEF, other byte intact.
- Halfword read at addr 0x00003 → resp_err = 1 one cycle after accept; csn stays 1 throughout.
- Read immediately followed by a write → at least 1 cycle between oen rising and dq_oe rising; oen and wen never both low.
- Assert rst_n low during WRITE → csn, wen, dq_oe go to 1/1/0 without a clock edge; no resp_valid after release.
- With SRAM_CTRL_PIPELINED_READ_EN, 4 consecutive reads → csn stays low; one resp every 2 cycles; rdata matches each address.
